// File: rtl/led_pwm_ctrl_pkg.sv
// Shared register map, channel mode encodings and field positions for the LED PWM controller.
package led_pwm_ctrl_pkg;

  localparam logic [7:0] ADDR_CTRL    = 8'h00;
  localparam logic [7:0] ADDR_BLINK   = 8'h01;
  localparam logic [7:0] ADDR_STATUS  = 8'h02;
  localparam logic [7:0] ADDR_CH_BASE = 8'h10;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_PWM   = 2'd2,
    MODE_BLINK = 2'd3
  } mode_e;

  localparam int unsigned CTRL_ENABLE_BIT   = 0;
  localparam int unsigned CTRL_PRESCALE_LSB = 8;
  localparam int unsigned CH_MODE_LSB       = 16;

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: bus-visible duty/mode, period-boundary shadows and the registered compare output.
module led_pwm_channel
  import led_pwm_ctrl_pkg::*;
#(
  parameter int unsigned PWM_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [PWM_WIDTH-1:0] wr_duty,
  input  logic [1:0]           wr_mode,
  input  logic [PWM_WIDTH-1:0] pwm_cnt,
  input  logic                 period_end,
  input  logic                 blink_phase,
  input  logic                 enable,
  output logic [31:0]          reg_value,
  output logic                 pwm_out
);

  logic [PWM_WIDTH-1:0] duty_q, duty_sh_q;
  mode_e                mode_q, mode_sh_q;
  logic                 pwm_q;
  logic                 lit;

  always_comb begin
    lit = 1'b0;
    unique case (mode_sh_q)
      MODE_OFF:   lit = 1'b0;
      MODE_ON:    lit = 1'b1;
      MODE_PWM:   lit = (pwm_cnt < duty_sh_q);
      MODE_BLINK: lit = (pwm_cnt < duty_sh_q) && blink_phase;
      default:    lit = 1'b0;
    endcase
  end

  // Shadows sample the pre-write register value, so a write landing on
  // period_end only takes effect one period later.
  always_ff @(posedge clk) begin
    if (reset) begin
      duty_q    <= '0;
      mode_q    <= MODE_OFF;
      duty_sh_q <= '0;
      mode_sh_q <= MODE_OFF;
      pwm_q     <= 1'b0;
    end else begin
      if (wr_en) begin
        duty_q <= wr_duty;
        mode_q <= mode_e'(wr_mode);
      end
      if (period_end) begin
        duty_sh_q <= duty_q;
        mode_sh_q <= mode_q;
      end
      pwm_q <= enable && lit;
    end
  end

  always_comb begin
    reg_value                       = '0;
    reg_value[PWM_WIDTH-1:0]        = duty_q;
    reg_value[CH_MODE_LSB +: 2]     = mode_q;
  end

  assign pwm_out = pwm_q;

endmodule

// File: rtl/led_pwm_ctrl.sv
// Multi-channel LED PWM controller: bus decode, prescaler, PWM and blink counters,
// with one led_pwm_channel per LED.
module led_pwm_ctrl
  import led_pwm_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CH         = 3,
  parameter int unsigned PWM_WIDTH      = 8,
  parameter int unsigned PRESCALE_WIDTH = 8,
  parameter int unsigned BLINK_WIDTH    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic              we,
  input  logic [7:0]        address,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic              ready,
  output logic              led_en,
  output logic [NUM_CH-1:0] led_pwm
);

  logic                      ctrl_en_q;
  logic [PRESCALE_WIDTH-1:0] prescale_q;
  logic [BLINK_WIDTH-1:0]    blink_half_q;
  logic [PRESCALE_WIDTH-1:0] ps_cnt_q;
  logic [PWM_WIDTH-1:0]      pwm_cnt_q;
  logic [BLINK_WIDTH-1:0]    blink_cnt_q;
  logic                      blink_phase_q;
  logic                      ready_q;
  logic                      led_en_q;

  logic                      bus_wr;
  logic                      tick;
  logic                      period_end;
  logic [BLINK_WIDTH-1:0]    blink_cnt_inc;
  logic [31:0]               ch_reg [NUM_CH];
  logic                      unused_wdata;

  assign bus_wr        = cs && we;
  assign tick          = (ps_cnt_q == prescale_q);
  assign period_end    = tick && (pwm_cnt_q == '1);
  assign blink_cnt_inc = blink_cnt_q + BLINK_WIDTH'(1);
  assign unused_wdata  = ^write_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_en_q     <= 1'b0;
      prescale_q    <= '0;
      blink_half_q  <= '0;
      ps_cnt_q      <= '0;
      pwm_cnt_q     <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      ready_q       <= 1'b0;
      led_en_q      <= 1'b0;
    end else begin
      if (bus_wr && address == ADDR_CTRL) begin
        ctrl_en_q  <= write_data[CTRL_ENABLE_BIT];
        prescale_q <= write_data[CTRL_PRESCALE_LSB +: PRESCALE_WIDTH];
      end
      if (bus_wr && address == ADDR_BLINK) begin
        blink_half_q <= write_data[BLINK_WIDTH-1:0];
      end
      ps_cnt_q <= tick ? '0 : ps_cnt_q + PRESCALE_WIDTH'(1);
      if (tick) begin
        pwm_cnt_q <= pwm_cnt_q + PWM_WIDTH'(1);
      end
      // A zero half-period parks the blink phase in the lit state.
      if (blink_half_q == '0) begin
        blink_phase_q <= 1'b1;
        blink_cnt_q   <= '0;
      end else if (period_end) begin
        if (blink_cnt_inc == blink_half_q) begin
          blink_phase_q <= ~blink_phase_q;
          blink_cnt_q   <= '0;
        end else begin
          blink_cnt_q <= blink_cnt_inc;
        end
      end
      ready_q  <= cs;
      led_en_q <= ctrl_en_q;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [7:0] ChAddr = ADDR_CH_BASE + 8'(i);
    led_pwm_channel #(
      .PWM_WIDTH (PWM_WIDTH)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .wr_en       (bus_wr && (address == ChAddr)),
      .wr_duty     (write_data[PWM_WIDTH-1:0]),
      .wr_mode     (write_data[CH_MODE_LSB +: 2]),
      .pwm_cnt     (pwm_cnt_q),
      .period_end  (period_end),
      .blink_phase (blink_phase_q),
      .enable      (ctrl_en_q),
      .reg_value   (ch_reg[i]),
      .pwm_out     (led_pwm[i])
    );
  end

  always_comb begin
    read_data = '0;
    if (cs && !we) begin
      if (address == ADDR_CTRL) begin
        read_data[CTRL_ENABLE_BIT]                      = ctrl_en_q;
        read_data[CTRL_PRESCALE_LSB +: PRESCALE_WIDTH]  = prescale_q;
      end else if (address == ADDR_BLINK) begin
        read_data[BLINK_WIDTH-1:0] = blink_half_q;
      end else if (address == ADDR_STATUS) begin
        read_data[PWM_WIDTH-1:0] = pwm_cnt_q;
        read_data[31]            = blink_phase_q;
      end else begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          if (address == ADDR_CH_BASE + 8'(i)) begin
            read_data = ch_reg[i];
          end
        end
      end
    end
  end

  assign ready  = ready_q;
  assign led_en = led_en_q;

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Self-checking bench for led_pwm_ctrl: directed scenarios plus random bus traffic,
// compared cycle by cycle against a behavioural model of the controller.
module tb_led_pwm_ctrl;

  localparam int NCH    = 3;
  localparam int PERIOD = 256;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           cs = 1'b0;
  logic           we = 1'b0;
  logic [7:0]     address = '0;
  logic [31:0]    write_data = '0;
  logic [31:0]    read_data;
  logic           ready;
  logic           led_en;
  logic [NCH-1:0] led_pwm;

  led_pwm_ctrl #(
    .NUM_CH         (NCH),
    .PWM_WIDTH      (8),
    .PRESCALE_WIDTH (8),
    .BLINK_WIDTH    (8)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .cs         (cs),
    .we         (we),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .led_en     (led_en),
    .led_pwm    (led_pwm)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state (plain integers).
  int m_en, m_prescale, m_half, m_ps, m_cnt, m_bcnt, m_phase;
  int m_duty [NCH];
  int m_mode [NCH];
  int m_duty_sh [NCH];
  int m_mode_sh [NCH];
  int m_out [NCH];
  int m_len, m_ready;
  bit m_last_pend;

  logic [NCH-1:0] pwm_s;
  logic [31:0]    rdata_s;
  int             hi [NCH];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int model_lit(input int mode, input int duty);
    case (mode)
      1:       return 1;
      2:       return (m_cnt < duty) ? 1 : 0;
      3:       return ((m_cnt < duty) && (m_phase != 0)) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic c, input logic w, input logic [7:0] a);
    int idx;
    if (!c || w) return 32'h0;
    if (a == 8'h00) return (32'(m_prescale) << 8) | 32'(m_en);
    if (a == 8'h01) return 32'(m_half);
    if (a == 8'h02) return (32'(m_phase) << 31) | 32'(m_cnt);
    idx = int'(a) - 16;
    if (idx >= 0 && idx < NCH) return (32'(m_mode[idx]) << 16) | 32'(m_duty[idx]);
    return 32'h0;
  endfunction

  task automatic model_step(input logic r, input logic c, input logic w, input logic [7:0] a,
                            input logic [31:0] d);
    bit tick, pend;
    int idx;
    if (r) begin
      m_en = 0; m_prescale = 0; m_half = 0; m_ps = 0; m_cnt = 0; m_bcnt = 0; m_phase = 1;
      for (int i = 0; i < NCH; i++) begin
        m_duty[i] = 0; m_mode[i] = 0; m_duty_sh[i] = 0; m_mode_sh[i] = 0; m_out[i] = 0;
      end
      m_len = 0; m_ready = 0; m_last_pend = 1'b0;
      return;
    end
    tick = (m_ps == m_prescale);
    pend = tick && (m_cnt == PERIOD - 1);
    m_last_pend = pend;
    for (int i = 0; i < NCH; i++) m_out[i] = m_en & model_lit(m_mode_sh[i], m_duty_sh[i]);
    m_len   = m_en;
    m_ready = int'(c);
    m_ps = tick ? 0 : (m_ps + 1) % 256;
    if (tick) m_cnt = (m_cnt + 1) % PERIOD;
    if (m_half == 0) begin
      m_phase = 1;
      m_bcnt  = 0;
    end else if (pend) begin
      m_bcnt = (m_bcnt + 1) % 256;
      if (m_bcnt == m_half) begin
        m_phase = 1 - m_phase;
        m_bcnt  = 0;
      end
    end
    if (pend) begin
      for (int i = 0; i < NCH; i++) begin
        m_duty_sh[i] = m_duty[i];
        m_mode_sh[i] = m_mode[i];
      end
    end
    if (c && w) begin
      idx = int'(a) - 16;
      if (a == 8'h00) begin
        m_en       = int'(d[0]);
        m_prescale = int'(d[15:8]);
      end else if (a == 8'h01) begin
        m_half = int'(d[7:0]);
      end else if (idx >= 0 && idx < NCH) begin
        m_duty[idx] = int'(d[7:0]);
        m_mode[idx] = int'(d[17:16]);
      end
    end
  endtask

  task automatic step(input logic r, input logic c, input logic w, input logic [7:0] a,
                      input logic [31:0] d);
    logic [NCH-1:0] exp_pwm;
    @(negedge clk);
    reset = r; cs = c; we = w; address = a; write_data = d;
    #1;
    rdata_s = read_data;
    check_eq("rdata", read_data, model_read(c, w, a));
    model_step(r, c, w, a, d);
    @(posedge clk);
    #1;
    for (int i = 0; i < NCH; i++) exp_pwm[i] = (m_out[i] != 0);
    pwm_s = led_pwm;
    check_eq("led_pwm", 32'(led_pwm), 32'(exp_pwm));
    check_eq("led_en", 32'(led_en), 32'(m_len));
    check_eq("ready", 32'(ready), 32'(m_ready));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    step(1'b0, 1'b1, 1'b1, a, d);
  endtask

  task automatic rd(input logic [7:0] a);
    step(1'b0, 1'b1, 1'b0, a, 32'h0);
  endtask

  task automatic idle_count(input int n);
    for (int i = 0; i < NCH; i++) hi[i] = 0;
    for (int k = 0; k < n; k++) begin
      idle(1);
      for (int i = 0; i < NCH; i++) hi[i] += int'(pwm_s[i]);
    end
  endtask

  // Runs idle cycles until a period boundary has just passed; bounded.
  task automatic wait_period_end();
    int budget = 5000;
    do begin
      idle(1);
      budget--;
    end while (!m_last_pend && budget > 0);
    if (!m_last_pend) check_eq("period_end_timeout", 32'(budget), 32'h1);
  endtask

  initial begin
    int sel;
    logic [7:0] a;
    logic [31:0] d;
    logic [7:0] addr_list [8];

    // Reset, then idle.
    step(1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
    step(1'b1, 1'b1, 1'b0, 8'h02, 32'h0);
    check_eq("status_rst_cnt", {24'h0, rdata_s[7:0]}, 32'h0);
    check_eq("status_rst_phase", 32'(rdata_s[31]), 32'h1);
    idle(300);
    check_eq("idle_pwm", 32'(led_pwm), 32'h0);
    check_eq("idle_en", 32'(led_en), 32'h0);

    // 25% duty on channel 0, prescale 0.
    wr(8'h00, 32'h0000_0001);
    wr(8'h10, 32'h0002_0040);
    wait_period_end();
    wait_period_end();
    idle_count(PERIOD);
    check_eq("ch0_duty40_hi", 32'(hi[0]), 32'd64);
    check_eq("led_en_on", 32'(led_en), 32'h1);

    // Prescale 3: period 1024 cycles.
    wr(8'h00, 32'h0000_0301);
    wr(8'h10, 32'h0000_0000);
    wr(8'h11, 32'h0002_0080);
    wr(8'h12, 32'h0001_0000);
    wait_period_end();
    wait_period_end();
    idle_count(4 * PERIOD);
    check_eq("ps3_ch0_off", 32'(hi[0]), 32'd0);
    check_eq("ps3_ch1_half", 32'(hi[1]), 32'd512);
    check_eq("ps3_ch2_on", 32'(hi[2]), 32'd1024);

    // Blink half-period 2 at full-scale duty.
    wr(8'h00, 32'h0000_0001);
    wr(8'h01, 32'h0000_0002);
    wr(8'h10, 32'h0003_00FF);
    wait_period_end();
    wait_period_end();
    idle_count(4 * PERIOD);
    check_eq("blink_ch0_hi", 32'(hi[0]), 32'd510);
    for (int k = 0; k < 6; k++) begin
      rd(8'h02);
      idle(200);
    end

    // Write landing exactly on the period boundary.
    wr(8'h01, 32'h0000_0000);
    wr(8'h10, 32'h0002_0040);
    wait_period_end();
    wait_period_end();
    for (int k = 0; k < 1000 && !(m_ps == m_prescale && m_cnt == PERIOD - 1); k++) idle(1);
    wr(8'h10, 32'h0002_0010);
    check_eq("boundary_write_edge", 32'(m_last_pend), 32'h1);
    idle_count(PERIOD);
    check_eq("old_duty_kept", 32'(hi[0]), 32'd64);
    idle_count(PERIOD);
    check_eq("new_duty_applied", 32'(hi[0]), 32'd16);

    // Reset mid-period with outputs high.
    wr(8'h10, 32'h0001_0000);
    wait_period_end();
    idle(37);
    check_eq("pre_rst_high", 32'(led_pwm[2]), 32'h1);
    step(1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
    check_eq("rst_pwm", 32'(led_pwm), 32'h0);
    check_eq("rst_en", 32'(led_en), 32'h0);
    rd(8'h00);
    check_eq("rst_ctrl", rdata_s, 32'h0);
    rd(8'h01);
    check_eq("rst_blink", rdata_s, 32'h0);
    rd(8'h10);
    check_eq("rst_ch0", rdata_s, 32'h0);
    rd(8'h12);
    check_eq("rst_ch2", rdata_s, 32'h0);
    rd(8'(16 + NCH));
    check_eq("oob_read", rdata_s, 32'h0);
    check_eq("oob_ready", 32'(ready), 32'h1);

    // Random traffic.
    addr_list = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h13, 8'h00};
    for (int k = 0; k < 4000; k++) begin
      sel = $urandom_range(0, 7);
      a   = (sel == 7) ? 8'($urandom_range(0, 255)) : addr_list[sel];
      d   = $urandom;
      if (a == 8'h00) begin
        d[15:8] = 8'($urandom_range(0, 2));
        d[0]    = ($urandom_range(0, 3) != 0);
      end else if (a == 8'h01) begin
        d[7:0] = 8'($urandom_range(0, 3));
      end
      sel = $urandom_range(0, 999);
      if (sel < 2)        step(1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
      else if (sel < 40)  step(1'b0, 1'b1, 1'b1, a, d);
      else if (sel < 120) step(1'b0, 1'b1, 1'b0, a, 32'h0);
      else                idle(1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
